// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer-phase state encoding and default bus/timeout sizing.
// Used by the core master, APB slaves and the interconnect bench.
package apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   localparam int APB_BUS_WIDTH      = 16;
   localparam int APB_TIMEOUT_CYCLES = 64;
   localparam int APB_TO_WIDTH       = 7;

endpackage

// File: rtl/apb_core_master_if.sv
// Core request/response handshake plus the APB3 master-port lane, as seen by the core master.
// master = the apb_core_master view; slave = the core + interconnect side driving it.
interface apb_core_master_if #(
   parameter int BUS_WIDTH = 16
);
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_write;
   logic [BUS_WIDTH-1:0] req_addr;
   logic [BUS_WIDTH-1:0] req_wdata;

   logic                 rsp_valid;
   logic [BUS_WIDTH-1:0] rsp_rdata;
   logic                 rsp_err;

   logic [BUS_WIDTH-1:0] M_PADDR;
   logic                 M_PWRITE;
   logic                 M_PSELx;
   logic                 M_PENABLE;
   logic [BUS_WIDTH-1:0] M_PWDATA;
   logic [BUS_WIDTH-1:0] M_PRDATA;
   logic                 M_PREADY;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, M_PRDATA, M_PREADY,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, M_PRDATA, M_PREADY,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA
   );

endinterface

// File: rtl/apb_timeout_ctr.sv
// Counts stalled ACCESS cycles; tc flags the stall cycle that reaches TIMEOUT_CYCLES.
// Zero latency on tc (combinational from count); TIMEOUT_CYCLES=0 keeps tc low forever.
module apb_timeout_ctr #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int TO_WIDTH       = 7
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [TO_WIDTH-1:0] LAST    = TO_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam bit                  ENABLED = (TIMEOUT_CYCLES != 0);

   logic [TO_WIDTH-1:0] cnt_q;
   logic [TO_WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + TO_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // This stall is the one that brings the count up to TIMEOUT_CYCLES.
   assign tc = ENABLED && en && (cnt_q == LAST);

endmodule

// File: rtl/apb_core_master.sv
// Core-side APB3 master: one request -> SETUP/ACCESS transfer, rsp_valid 3 cycles after accept plus wait states.
// req_ready only in IDLE (single outstanding); stalled slaves are aborted after TIMEOUT_CYCLES.
module apb_core_master
   import apb_pkg::*;
#(
   parameter int BUS_WIDTH      = APB_BUS_WIDTH,
   parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES,
   parameter int TO_WIDTH       = APB_TO_WIDTH
) (
   input logic               clk,
   input logic               reset,
   apb_core_master_if.master bus
);

   apb_state_e           state_q,     state_d;
   logic [BUS_WIDTH-1:0] paddr_q,     paddr_d;
   logic [BUS_WIDTH-1:0] pwdata_q,    pwdata_d;
   logic                 pwrite_q,    pwrite_d;
   logic                 psel_q,      psel_d;
   logic                 penable_q,   penable_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [BUS_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                 rsp_err_q,   rsp_err_d;

   logic to_clr;
   logic to_en;
   logic to_tc;

   apb_timeout_ctr #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TO_WIDTH       (TO_WIDTH)
   ) u_timeout (
      .clk   (clk),
      .reset (reset),
      .clr   (to_clr),
      .en    (to_en),
      .tc    (to_tc)
   );

   always_comb begin
      state_d     = state_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pwrite_d    = pwrite_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      to_clr      = 1'b0;
      to_en       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               paddr_d  = bus.req_addr;
               pwdata_d = bus.req_wdata;
               pwrite_d = bus.req_write;
               psel_d   = 1'b1;
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            penable_d = 1'b1;
            to_clr    = 1'b1;
            state_d   = ST_ACCESS;
         end
         ST_ACCESS: begin
            // PREADY is checked first so a completion in the timeout cycle is not an error.
            if (bus.M_PREADY) begin
               if (!pwrite_q) begin
                  rsp_rdata_d = bus.M_PRDATA;
               end
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               to_en = 1'b1;
               if (to_tc) begin
                  rsp_rdata_d = '0;
                  rsp_err_d   = 1'b1;
                  rsp_valid_d = 1'b1;
                  psel_d      = 1'b0;
                  penable_d   = 1'b0;
                  state_d     = ST_IDLE;
               end
            end
         end
         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pwrite_q    <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pwrite_q    <= pwrite_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.req_ready = (state_q == ST_IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.M_PADDR   = paddr_q;
   assign bus.M_PWDATA  = pwdata_q;
   assign bus.M_PWRITE  = pwrite_q;
   assign bus.M_PSELx   = psel_q;
   assign bus.M_PENABLE = penable_q;

endmodule

// File: tb/tb_apb_core_master.sv
// Directed bench for apb_core_master with TIMEOUT_CYCLES=4; inputs change and outputs are
// sampled on the falling edge, so each negedge marks the cycle T0, T1, ... of a transfer.
module tb_apb_core_master;

   localparam int BW = 16;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   apb_core_master_if #(.BUS_WIDTH(BW)) bus ();

   apb_core_master #(
      .BUS_WIDTH      (BW),
      .TIMEOUT_CYCLES (4),
      .TO_WIDTH       (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      reset = 1'b0;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
      bus.M_PRDATA = '0; bus.M_PREADY = 1'b0;
      #2;
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", bus.req_ready); end
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", bus.rsp_valid); end
      checks++; if (bus.M_PSELx !== 1'b0 || bus.M_PENABLE !== 1'b0) begin errors++; $display("FAIL rst_psel_penable got %b%b exp 00", bus.M_PSELx, bus.M_PENABLE); end
      checks++; if (bus.M_PADDR !== 16'h0 || bus.rsp_rdata !== 16'h0 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_regs paddr %h rdata %h err %b exp 0", bus.M_PADDR, bus.rsp_rdata, bus.rsp_err); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_load_zero_wait();
      @(negedge clk); // T0
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL t1_ready_t0 got %b exp 1", bus.req_ready); end
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 16'h00C0; bus.req_wdata = 16'h0;
      bus.M_PREADY = 1'b1; bus.M_PRDATA = 16'h1234;
      @(negedge clk); // T1
      bus.req_valid = 1'b0;
      checks++; if (bus.M_PSELx !== 1'b1 || bus.M_PENABLE !== 1'b0) begin errors++; $display("FAIL t1_setup psel/penable got %b%b exp 10", bus.M_PSELx, bus.M_PENABLE); end
      checks++; if (bus.M_PADDR !== 16'h00C0 || bus.M_PWRITE !== 1'b0) begin errors++; $display("FAIL t1_addr got %h/%b exp 00c0/0", bus.M_PADDR, bus.M_PWRITE); end
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL t1_ready_setup got %b exp 0", bus.req_ready); end
      @(negedge clk); // T2
      checks++; if (bus.M_PSELx !== 1'b1 || bus.M_PENABLE !== 1'b1) begin errors++; $display("FAIL t1_access psel/penable got %b%b exp 11", bus.M_PSELx, bus.M_PENABLE); end
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL t1_early_rsp got %b exp 0", bus.rsp_valid); end
      @(negedge clk); // T3
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL t1_rsp valid/err got %b/%b exp 1/0", bus.rsp_valid, bus.rsp_err); end
      checks++; if (bus.rsp_rdata !== 16'h1234) begin errors++; $display("FAIL t1_rdata got %h exp 1234", bus.rsp_rdata); end
      checks++; if (bus.M_PSELx !== 1'b0 || bus.M_PENABLE !== 1'b0) begin errors++; $display("FAIL t1_idle psel/penable got %b%b exp 00", bus.M_PSELx, bus.M_PENABLE); end
      @(negedge clk); // T4
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL t1_rsp_pulse got %b exp 0", bus.rsp_valid); end
      bus.M_PREADY = 1'b0;
   endtask

   task automatic test_store_waits();
      @(negedge clk); // T0
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 16'h00B1; bus.req_wdata = 16'hBEEF;
      bus.M_PREADY = 1'b0; bus.M_PRDATA = 16'hFFFF;
      @(negedge clk); // T1
      bus.req_valid = 1'b0; bus.req_wdata = 16'h0000;
      checks++; if (bus.M_PWDATA !== 16'hBEEF || bus.M_PWRITE !== 1'b1) begin errors++; $display("FAIL t2_setup pwdata/pwrite got %h/%b exp beef/1", bus.M_PWDATA, bus.M_PWRITE); end
      for (int k = 2; k <= 4; k++) begin
         @(negedge clk);
         checks++; if (bus.M_PENABLE !== 1'b1 || bus.M_PWDATA !== 16'hBEEF || bus.M_PADDR !== 16'h00B1) begin errors++; $display("FAIL t2_wait T%0d penable %b pwdata %h paddr %h exp 1 beef 00b1", k, bus.M_PENABLE, bus.M_PWDATA, bus.M_PADDR); end
         checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL t2_wait_rsp T%0d got %b exp 0", k, bus.rsp_valid); end
      end
      @(negedge clk); // T5
      checks++; if (bus.M_PENABLE !== 1'b1 || bus.M_PWDATA !== 16'hBEEF) begin errors++; $display("FAIL t2_last_access penable %b pwdata %h exp 1 beef", bus.M_PENABLE, bus.M_PWDATA); end
      bus.M_PREADY = 1'b1;
      @(negedge clk); // T6
      bus.M_PREADY = 1'b0;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL t2_rsp valid/err got %b/%b exp 1/0", bus.rsp_valid, bus.rsp_err); end
      checks++; if (bus.rsp_rdata !== 16'h1234) begin errors++; $display("FAIL t2_rdata_kept got %h exp 1234", bus.rsp_rdata); end
      @(negedge clk); // T7
      checks++; if (bus.M_PADDR !== 16'h00B1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL t2_idle_hold paddr %h rsp %b exp 00b1 0", bus.M_PADDR, bus.rsp_valid); end
   endtask

   task automatic test_timeout();
      @(negedge clk); // T0
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 16'h00A0;
      bus.M_PREADY = 1'b0; bus.M_PRDATA = 16'h7777;
      @(negedge clk); // T1
      bus.req_valid = 1'b0;
      for (int k = 2; k <= 5; k++) begin
         @(negedge clk);
         checks++; if (bus.M_PSELx !== 1'b1 || bus.M_PENABLE !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL t3_stall T%0d psel %b penable %b rsp %b exp 1 1 0", k, bus.M_PSELx, bus.M_PENABLE, bus.rsp_valid); end
      end
      @(negedge clk); // T6
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 16'h0) begin errors++; $display("FAIL t3_abort valid %b err %b rdata %h exp 1 1 0000", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
      checks++; if (bus.M_PSELx !== 1'b0 || bus.M_PENABLE !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL t3_abort_idle psel %b penable %b ready %b exp 0 0 1", bus.M_PSELx, bus.M_PENABLE, bus.req_ready); end
      bus.req_valid = 1'b1; bus.req_addr = 16'h00A2; bus.M_PREADY = 1'b1; bus.M_PRDATA = 16'h5A5A;
      @(negedge clk); // T7: SETUP of the follow-up load
      bus.req_valid = 1'b0;
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL t3_rsp_pulse got %b exp 0", bus.rsp_valid); end
      @(negedge clk); // T8
      @(negedge clk); // T9
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 16'h5A5A) begin errors++; $display("FAIL t3_recover valid %b err %b rdata %h exp 1 0 5a5a", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
      bus.M_PREADY = 1'b0;
   endtask

   task automatic test_race();
      @(negedge clk); // T0
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 16'h00D0;
      bus.M_PREADY = 1'b0; bus.M_PRDATA = 16'h0000;
      @(negedge clk); // T1
      bus.req_valid = 1'b0;
      repeat (3) @(negedge clk); // T2..T4 stalled
      @(negedge clk); // T5: fourth ACCESS cycle, the timeout cycle
      checks++; if (bus.M_PSELx !== 1'b1 || bus.M_PENABLE !== 1'b1) begin errors++; $display("FAIL t6_still_access psel %b penable %b exp 1 1", bus.M_PSELx, bus.M_PENABLE); end
      bus.M_PREADY = 1'b1; bus.M_PRDATA = 16'hC0DE;
      @(negedge clk); // T6
      bus.M_PREADY = 1'b0;
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL t6_race valid/err got %b/%b exp 1/0", bus.rsp_valid, bus.rsp_err); end
      checks++; if (bus.rsp_rdata !== 16'hC0DE) begin errors++; $display("FAIL t6_race_rdata got %h exp c0de", bus.rsp_rdata); end
   endtask

   task automatic test_back_to_back();
      int   pulses = 0;
      logic exp_ready;
      logic exp_rsp;
      logic [15:0] exp_rd;
      for (int t = 0; t <= 9; t++) begin
         @(negedge clk);
         exp_ready = (t % 3 == 0);
         exp_rsp   = (t != 0) && (t % 3 == 0);
         checks++; if (bus.req_ready !== exp_ready) begin errors++; $display("FAIL t4_ready T%0d got %b exp %b", t, bus.req_ready, exp_ready); end
         checks++; if (bus.rsp_valid !== exp_rsp) begin errors++; $display("FAIL t4_rsp T%0d got %b exp %b", t, bus.rsp_valid, exp_rsp); end
         if (bus.rsp_valid === 1'b1) pulses++;
         if (exp_rsp) begin
            exp_rd = 16'(32'h1000 + t - 1);
            checks++; if (bus.rsp_rdata !== exp_rd) begin errors++; $display("FAIL t4_rdata T%0d got %h exp %h", t, bus.rsp_rdata, exp_rd); end
         end
         bus.req_valid = (t < 7); bus.req_write = 1'b0; bus.req_addr = 16'h0040;
         bus.M_PREADY = 1'b1; bus.M_PRDATA = 16'(32'h1000 + t);
      end
      @(negedge clk);
      bus.M_PREADY = 1'b0;
      if (bus.rsp_valid === 1'b1) pulses++;
      checks++; if (pulses != 3) begin errors++; $display("FAIL t4_pulse_count got %0d exp 3", pulses); end
      checks++; if (bus.M_PSELx !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL t4_final_idle psel %b ready %b exp 0 1", bus.M_PSELx, bus.req_ready); end
   endtask

   task automatic test_reset_mid_access();
      @(negedge clk); // T0
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 16'h00E0; bus.req_wdata = 16'h1111;
      bus.M_PREADY = 1'b0;
      @(negedge clk); // T1
      bus.req_valid = 1'b0;
      @(negedge clk); // T2
      checks++; if (bus.M_PSELx !== 1'b1 || bus.M_PENABLE !== 1'b1) begin errors++; $display("FAIL t5_in_access psel %b penable %b exp 1 1", bus.M_PSELx, bus.M_PENABLE); end
      #2 reset = 1'b0;
      #1;
      checks++; if (bus.M_PSELx !== 1'b0 || bus.M_PENABLE !== 1'b0) begin errors++; $display("FAIL t5_async_drop psel %b penable %b exp 0 0", bus.M_PSELx, bus.M_PENABLE); end
      checks++; if (bus.rsp_valid !== 1'b0 || bus.M_PADDR !== 16'h0) begin errors++; $display("FAIL t5_reset_outputs rsp %b paddr %h exp 0 0000", bus.rsp_valid, bus.M_PADDR); end
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.M_PSELx !== 1'b0) begin errors++; $display("FAIL t5_after_release %0d rsp %b ready %b psel %b exp 0 1 0", k, bus.rsp_valid, bus.req_ready, bus.M_PSELx); end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_load_zero_wait();
      test_store_waits();
      test_timeout();
      test_race();
      test_back_to_back();
      test_reset_mid_access();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
